// File: rtl/spi_master.sv
// ============================================================================
//  Module      : spi_master
//  Description : SPI mode-0 master, 8-bit frames, CLK_DIV clk cycles per
//                SCLK half-period. Define SPI_MASTER_LSB_FIRST_EN for
//                LSB-first bit order.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       ready,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       SCLK,
    output logic       ss_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int                 c_CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP0  = 2'd1,
        CP1  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_half_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_tx_sr;
    logic [7:0]         r_rx_sr;

    logic               w_first_bit;
    logic               w_next_bit;
    logic [7:0]         w_tx_shift;
    logic [7:0]         w_rx_shift;

    // Bit order only changes which end of the shift registers is used.
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign w_first_bit = tx_data[0];
    assign w_next_bit  = r_tx_sr[1];
    assign w_tx_shift  = {1'b0, r_tx_sr[7:1]};
    assign w_rx_shift  = {MISO, r_rx_sr[7:1]};
`else
    assign w_first_bit = tx_data[7];
    assign w_next_bit  = r_tx_sr[6];
    assign w_tx_shift  = {r_tx_sr[6:0], 1'b0};
    assign w_rx_shift  = {r_rx_sr[6:0], MISO};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_half_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_tx_sr    <= 8'h00;
            r_rx_sr    <= 8'h00;
            ready      <= 1'b1;
            done       <= 1'b0;
            rx_data    <= 8'h00;
            SCLK       <= 1'b0;
            ss_n       <= 1'b1;
            MOSI       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_tx_sr    <= tx_data;
                        r_rx_sr    <= 8'h00;
                        r_bit_cnt  <= 3'd0;
                        r_half_cnt <= '0;
                        MOSI       <= w_first_bit;
                        ss_n       <= 1'b0;
                        ready      <= 1'b0;
                        r_state    <= CP0;
                    end
                end
                CP0: begin
                    if (r_half_cnt == c_LAST) begin
                        // Sample MISO on the edge that raises SCLK.
                        r_half_cnt <= '0;
                        r_rx_sr    <= w_rx_shift;
                        SCLK       <= 1'b1;
                        r_state    <= CP1;
                    end else begin
                        r_half_cnt <= r_half_cnt + c_CNT_W'(1);
                    end
                end
                CP1: begin
                    if (r_half_cnt == c_LAST) begin
                        r_half_cnt <= '0;
                        SCLK       <= 1'b0;
                        if (r_bit_cnt == 3'd7) begin
                            ss_n    <= 1'b1;
                            MOSI    <= 1'b0;
                            done    <= 1'b1;
                            rx_data <= r_rx_sr;
                            r_state <= DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx_sr   <= w_tx_shift;
                            MOSI      <= w_next_bit;
                            r_state   <= CP0;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + c_CNT_W'(1);
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
//  Module      : tb_spi_master
//  Description : Self-checking bench for spi_master (CLK_DIV=4 and CLK_DIV=1)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master;

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit c_LSB = 1'b1;
`else
    localparam bit c_LSB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start;
    logic [1:0] ready, done, sclk, ss_n, mosi, miso;
    logic [7:0] tx_data [2];
    logic [7:0] rx_data [2];

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .tx_data(tx_data[0]),
        .ready(ready[0]), .done(done[0]), .rx_data(rx_data[0]),
        .SCLK(sclk[0]), .ss_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .tx_data(tx_data[1]),
        .ready(ready[1]), .done(done[1]), .rx_data(rx_data[1]),
        .SCLK(sclk[1]), .ss_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
    );

    int         n_pass  = 0;
    int         n_total = 0;

    logic [7:0] slave_pat [2] = '{8'h00, 8'h00};
    int         fcnt      [2] = '{0, 0};
    int         mosi_n    [2] = '{0, 0};
    int         done_cnt  [2] = '{0, 0};
    int         proto_err [2] = '{0, 0};
    logic       prev_sclk [2] = '{1'b0, 1'b0};
    logic       prev_ss_n [2] = '{1'b1, 1'b1};
    logic       prev_done [2] = '{1'b0, 1'b0};
    logic       mosi_bits [2][16];

    function automatic int div_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // k-th bit on the wire for a byte, in the configured bit order.
    function automatic logic wire_bit(input logic [7:0] b, input int k);
        int kk;
        kk = (k > 7) ? 7 : k;
        return c_LSB ? b[kk] : b[7-kk];
    endfunction

    // Slave model (mode 0) and protocol monitor, sampled on falling clk.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ss_n[d] !== 1'b0) fcnt[d] = 0;
            else if (prev_sclk[d] === 1'b1 && sclk[d] === 1'b0) fcnt[d] = fcnt[d] + 1;
            if (prev_ss_n[d] === 1'b1 && ss_n[d] === 1'b0) mosi_n[d] = 0;
            if (prev_sclk[d] === 1'b0 && sclk[d] === 1'b1 && mosi_n[d] < 16) begin
                mosi_bits[d][mosi_n[d]] = mosi[d];
                mosi_n[d] = mosi_n[d] + 1;
            end
            miso[d] = wire_bit(slave_pat[d], fcnt[d]);
            if (done[d] === 1'b1) begin
                done_cnt[d] = done_cnt[d] + 1;
                if (prev_done[d] === 1'b1 || ready[d] !== 1'b0) proto_err[d] = proto_err[d] + 1;
            end
            prev_sclk[d] = sclk[d];
            prev_ss_n[d] = ss_n[d];
            prev_done[d] = done[d];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Called at a falling edge inside the cycle in which start is to be high.
    task automatic launch(input int d, input logic [7:0] tx, input logic [7:0] pat);
        tx_data[d]   = tx;
        slave_pat[d] = pat;
        start[d]     = 1'b1;
        @(negedge clk);
        start[d]     = 1'b0;
    endtask

    task automatic wait_done(input int d, input int inj_start, input int inj_rst,
                             output int dcyc, output int sclk_bad);
        int  div;
        int  cyc;
        bit  stop;
        div      = div_of(d);
        cyc      = 1;
        stop     = 1'b0;
        dcyc     = 0;
        sclk_bad = 0;
        while (!stop) begin
            if (cyc <= 16*div &&
                (sclk[d] !== 1'(((cyc-1)/div) % 2) || ss_n[d] !== 1'b0))
                sclk_bad++;
            if (done[d] === 1'b1) begin
                dcyc = cyc;
                stop = 1'b1;
            end else if (cyc == inj_rst) begin
                rst  = 1'b1;
                stop = 1'b1;
            end else if (cyc >= 16*div + 20) begin
                stop = 1'b1;
            end else begin
                start[d] = (cyc == inj_start);
                if (cyc == inj_start) tx_data[d] = 8'h12;
                @(negedge clk);
                cyc++;
            end
        end
        start[d] = 1'b0;
    endtask

    task automatic check_frame(input int d, input logic [7:0] tx, input logic [7:0] pat,
                               input int dcyc, input int sclk_bad);
        logic [7:0] obs_seq, exp_seq;
        for (int k = 0; k < 8; k++) begin
            obs_seq[7-k] = mosi_bits[d][k];
            exp_seq[7-k] = wire_bit(tx, k);
        end
        check($sformatf("d%0d_done_cycle", d), dcyc, 16*div_of(d) + 1);
        check($sformatf("d%0d_rx_data", d), {24'h0, rx_data[d]}, {24'h0, pat});
        check($sformatf("d%0d_mosi_bits", d), {24'h0, obs_seq}, {24'h0, exp_seq});
        check($sformatf("d%0d_mosi_count", d), mosi_n[d], 8);
        check($sformatf("d%0d_sclk_waveform_errs", d), sclk_bad, 0);
        check($sformatf("d%0d_ready_ss_in_done", d), {30'h0, ready[d], ss_n[d]}, 32'h1);
    endtask

    task automatic frame(input int d, input logic [7:0] tx, input logic [7:0] pat, input int inj_start);
        int dcyc, bad;
        @(negedge clk);
        launch(d, tx, pat);
        wait_done(d, inj_start, 0, dcyc, bad);
        check_frame(d, tx, pat, dcyc, bad);
        @(negedge clk);
        check($sformatf("d%0d_ready_after_done", d), {30'h0, ready[d], done[d]}, 32'h2);
    endtask

    initial begin
        int         dcyc, bad, dc0;
        logic [7:0] tx, pat;

        rst        = 1'b1;
        start      = 2'b00;
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("d%0d_reset_state", d),
                  {19'h0, ready[d], done[d], ss_n[d], sclk[d], mosi[d], rx_data[d]},
                  {19'h0, 5'b10100, 8'h00});
        rst = 1'b0;

        // Reference frame: A5 out, 3C back, done at cycle 65.
        frame(0, 8'hA5, 8'h3C, 0);

        for (int i = 0; i < 4; i++) frame(0, 8'($urandom), 8'($urandom), 0);
        for (int i = 0; i < 4; i++) frame(1, 8'($urandom), 8'($urandom), 0);
        frame(1, 8'h81, 8'($urandom), 0);
        frame(1, 8'h01, 8'h01, 0);

        // Back-to-back frames: start in the first IDLE cycle after done.
        @(negedge clk);
        pat = 8'($urandom);
        launch(0, 8'hFF, pat);
        wait_done(0, 0, 0, dcyc, bad);
        check_frame(0, 8'hFF, pat, dcyc, bad);
        @(negedge clk);
        check("b2b_idle_gap", {30'h0, ready[0], ss_n[0]}, 32'h3);
        pat = 8'($urandom);
        launch(0, 8'h00, pat);
        check("b2b_ss_low_after_gap", {31'h0, ss_n[0]}, 32'h0);
        wait_done(0, 0, 0, dcyc, bad);
        check_frame(0, 8'h00, pat, dcyc, bad);

        // A start pulsed mid-frame must be ignored.
        repeat (3) @(negedge clk);
        dc0 = done_cnt[0];
        tx  = 8'($urandom);
        pat = 8'($urandom) | 8'h01;
        frame(0, tx, pat, 20);
        repeat (80) @(negedge clk);
        check("ignored_start_done_count", done_cnt[0] - dc0, 1);
        check("ignored_start_ready", {31'h0, ready[0]}, 32'h1);

        // Reset at cycle 30 aborts the frame without done.
        @(negedge clk);
        launch(0, 8'($urandom), 8'($urandom));
        wait_done(0, 0, 30, dcyc, bad);
        dc0 = done_cnt[0];
        @(negedge clk);
        check("abort_outputs", {28'h0, ss_n[0], sclk[0], ready[0], done[0]}, 32'b1010);
        check("abort_rx_data", {24'h0, rx_data[0]}, 32'h0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_no_done", done_cnt[0] - dc0, 0);
        check("abort_idle_ready", {30'h0, ready[0], ss_n[0]}, 32'h3);

        check("d0_protocol_errs", proto_err[0], 0);
        check("d1_protocol_errs", proto_err[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
